// File: rtl/helios_syndrome_framer.sv
// Serialises syndrome rounds into the decoder's byte protocol: one start byte per reset,
// then a header plus byte-packed rounds per frame, with a credit limit on frames in flight.
`timescale 1ns/1ps
module helios_syndrome_framer #(
    parameter int         GRID_WIDTH_X       = 4,
    parameter int         GRID_WIDTH_Z       = 1,
    parameter int         MEASUREMENT_ROUNDS = 2,
    parameter logic [7:0] START_MSG          = 8'h01,
    parameter logic [7:0] HEADER_MSG         = 8'h02,
    parameter int         MAX_OUTSTANDING    = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [GRID_WIDTH_X*GRID_WIDTH_Z-1:0] round_data,
    input  logic                                 round_valid,
    output logic                                 round_ready,
    output logic [7:0]                           output_data,
    output logic                                 output_valid,
    input  logic                                 output_ready,
    input  logic                                 result_done,
    output logic [3:0]                           outstanding,
    output logic [15:0]                          frames_sent,
    output logic                                 protocol_error
);
    localparam int PU_PER_ROUND    = GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int BYTES_PER_ROUND = (PU_PER_ROUND + 7) >> 3;
    localparam int LATCH_W         = 8 * BYTES_PER_ROUND;
    localparam int BIDX_W          = (BYTES_PER_ROUND > 1) ? $clog2(BYTES_PER_ROUND) : 1;
    localparam int RIDX_W          = (MEASUREMENT_ROUNDS > 1) ? $clog2(MEASUREMENT_ROUNDS) : 1;
    localparam logic [BIDX_W-1:0] BYTE_LAST    = BIDX_W'(BYTES_PER_ROUND - 1);
    localparam logic [RIDX_W-1:0] ROUND_LAST   = RIDX_W'(MEASUREMENT_ROUNDS - 1);
    localparam logic [3:0]        CREDIT_LIMIT = 4'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {ST_START, ST_IDLE, ST_HDR, ST_LOAD, ST_SEND} state_t;

    state_t              state_reg;
    logic [LATCH_W-1:0]  latch_reg;
    logic [BIDX_W-1:0]   byte_idx_reg;
    logic [RIDX_W-1:0]   round_idx_reg;
    logic [3:0]          outstanding_reg;
    logic [15:0]         frames_sent_reg;
    logic                protocol_error_reg;

    logic                byte_xfer;
    logic                round_xfer;
    logic                frame_end;

    // Byte view of the latched round, padded to a power of two so any index is in range.
    logic [7:0] latch_bytes [1 << BIDX_W];
    for (genvar gi = 0; gi < (1 << BIDX_W); gi++) begin : g_bytes
        if (gi < BYTES_PER_ROUND) begin : g_live
            assign latch_bytes[gi] = latch_reg[8*gi +: 8];
        end else begin : g_pad
            assign latch_bytes[gi] = 8'h00;
        end
    end

    always_comb begin
        output_valid = 1'b0;
        output_data  = 8'h00;
        case (state_reg)
            ST_START: begin
                output_valid = 1'b1;
                output_data  = START_MSG;
            end
            ST_HDR: begin
                output_valid = 1'b1;
                output_data  = HEADER_MSG;
            end
            ST_SEND: begin
                output_valid = 1'b1;
                output_data  = latch_bytes[byte_idx_reg];
            end
            default: ;
        endcase
    end

    assign round_ready = (state_reg == ST_LOAD);
    assign byte_xfer   = output_valid && output_ready;
    assign round_xfer  = round_valid && round_ready;
    assign frame_end   = (state_reg == ST_SEND) && byte_xfer &&
                         (byte_idx_reg == BYTE_LAST) && (round_idx_reg == ROUND_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= ST_START;
            latch_reg          <= '0;
            byte_idx_reg       <= '0;
            round_idx_reg      <= '0;
            outstanding_reg    <= 4'd0;
            frames_sent_reg    <= 16'd0;
            protocol_error_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_START: if (byte_xfer) state_reg <= ST_IDLE;
                ST_IDLE:  if (outstanding_reg < CREDIT_LIMIT) state_reg <= ST_HDR;
                ST_HDR: begin
                    if (byte_xfer) begin
                        round_idx_reg <= '0;
                        state_reg     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (round_xfer) begin
                        latch_reg    <= LATCH_W'(round_data);
                        byte_idx_reg <= '0;
                        state_reg    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (byte_xfer) begin
                        if (byte_idx_reg != BYTE_LAST) begin
                            byte_idx_reg <= byte_idx_reg + 1'b1;
                        end else if (round_idx_reg != ROUND_LAST) begin
                            round_idx_reg <= round_idx_reg + 1'b1;
                            state_reg     <= ST_LOAD;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_START;
            endcase

            if (frame_end) frames_sent_reg <= frames_sent_reg + 16'd1;

            // A result arriving on the same edge a frame ends cancels that frame's credit.
            if (frame_end && !result_done) begin
                outstanding_reg <= outstanding_reg + 4'd1;
            end else if (!frame_end && result_done) begin
                if (outstanding_reg != 4'd0) outstanding_reg <= outstanding_reg - 4'd1;
                else protocol_error_reg <= 1'b1;
            end
        end
    end

    assign outstanding    = outstanding_reg;
    assign frames_sent    = frames_sent_reg;
    assign protocol_error = protocol_error_reg;
endmodule

// File: tb/tb_helios_syndrome_framer.sv
// Bench for helios_syndrome_framer: three configurations (default, 6x2x1 grid, two credits)
// checked against byte streams built from the round values and counters tracked per frame.
`timescale 1ns/1ps
module tb_helios_syndrome_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst   [3];
    logic        rv    [3];
    logic [11:0] rdat  [3];
    logic        rr    [3];
    logic [7:0]  od    [3];
    logic        ov    [3];
    logic        ordy  [3];
    logic        rdone [3];
    logic [3:0]  outst [3];
    logic [15:0] fsent [3];
    logic        perr  [3];

    logic [7:0]  cap [3][$];
    logic [7:0]  ex [$];
    logic        rand_ready = 1'b0;

    helios_syndrome_framer u_a (
        .clk(clk), .reset(rst[0]), .round_data(rdat[0][3:0]), .round_valid(rv[0]),
        .round_ready(rr[0]), .output_data(od[0]), .output_valid(ov[0]), .output_ready(ordy[0]),
        .result_done(rdone[0]), .outstanding(outst[0]), .frames_sent(fsent[0]),
        .protocol_error(perr[0]));

    helios_syndrome_framer #(.GRID_WIDTH_X(6), .GRID_WIDTH_Z(2), .MEASUREMENT_ROUNDS(1)) u_b (
        .clk(clk), .reset(rst[1]), .round_data(rdat[1]), .round_valid(rv[1]),
        .round_ready(rr[1]), .output_data(od[1]), .output_valid(ov[1]), .output_ready(ordy[1]),
        .result_done(rdone[1]), .outstanding(outst[1]), .frames_sent(fsent[1]),
        .protocol_error(perr[1]));

    helios_syndrome_framer #(.MAX_OUTSTANDING(2)) u_c (
        .clk(clk), .reset(rst[2]), .round_data(rdat[2][3:0]), .round_valid(rv[2]),
        .round_ready(rr[2]), .output_data(od[2]), .output_valid(ov[2]), .output_ready(ordy[2]),
        .result_done(rdone[2]), .outstanding(outst[2]), .frames_sent(fsent[2]),
        .protocol_error(perr[2]));

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // Byte monitor: records every transfer and checks that stalled bytes hold still.
    for (genvar gi = 0; gi < 3; gi++) begin : g_mon
        logic       stalled = 1'b0;
        logic [7:0] held    = 8'h00;
        always @(negedge clk) begin
            if (rst[gi]) begin
                stalled <= 1'b0;
            end else begin
                if (stalled) begin
                    check($sformatf("hold_valid_d%0d", gi), ov[gi], 1);
                    check($sformatf("hold_data_d%0d", gi), od[gi], held);
                end
                check($sformatf("ready_excl_d%0d", gi), rr[gi] && ov[gi], 0);
                if (ov[gi] && ordy[gi]) cap[gi].push_back(od[gi]);
                stalled <= ov[gi] && !ordy[gi];
                held    <= od[gi];
            end
        end
    end

    // Expected bytes of one round: low byte first, value zero-extended.
    function automatic void model_round(int nbytes, logic [11:0] v);
        for (int b = 0; b < nbytes; b++) ex.push_back(8'(v >> (8 * b)));
    endfunction

    task automatic give_round(input int d, input logic [11:0] v);
        int n = 0;
        rdat[d] = v;
        rv[d]   = 1'b1;
        @(negedge clk);
        while (!rr[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("round_accept_d%0d", d), rr[d], 1);
        @(posedge clk); #1;
        rv[d] = 1'b0;
    endtask

    task automatic expect_bytes(input int d, input string tag);
        int n = 0;
        int i = 0;
        logic [7:0] got;
        while (cap[d].size() < ex.size() && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_count"}, cap[d].size() >= ex.size(), 1);
        while (ex.size() > 0) begin
            if (cap[d].size() > 0) got = cap[d].pop_front();
            else got = 8'hEE;
            check($sformatf("%s_byte%0d", tag, i), got, ex.pop_front());
            i++;
        end
        @(negedge clk);
    endtask

    task automatic pulse_done(input int d);
        @(posedge clk); #1;
        rdone[d] = 1'b1;
        @(posedge clk); #1;
        rdone[d] = 1'b0;
    endtask

    typedef struct {
        logic [3:0] r0;
        logic [3:0] r1;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t vt [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fs_model;
        logic [11:0] r0;
        logic [11:0] r1;

        vt[0] = '{4'hA, 4'h3, 8'h0A, 8'h03};
        vt[1] = '{4'hF, 4'h0, 8'h0F, 8'h00};
        vt[2] = '{4'h5, 4'hC, 8'h05, 8'h0C};
        vt[3] = '{4'h0, 4'h8, 8'h00, 8'h08};

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; rv[d] = 1'b0; rdat[d] = '0; ordy[d] = 1'b0; rdone[d] = 1'b0;
        end
        fork
            forever begin
                @(posedge clk); #1;
                if (rand_ready) ordy[0] = 1'($urandom_range(0, 1));
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_valid_d%0d", d), ov[d], 1);
            check($sformatf("rst_data_d%0d", d), od[d], 8'h01);
            check($sformatf("rst_rready_d%0d", d), rr[d], 0);
            check($sformatf("rst_outst_d%0d", d), outst[d], 0);
            check($sformatf("rst_fsent_d%0d", d), fsent[d], 0);
            check($sformatf("rst_perr_d%0d", d), perr[d], 0);
        end

        // Default configuration: table vectors, one frame each with credit limit 1.
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        ex.push_back(8'h01);
        expect_bytes(0, "start_a");
        for (int i = 0; i < 4; i++) begin
            ex.push_back(8'h02);
            give_round(0, {8'h00, vt[i].r0});
            give_round(0, {8'h00, vt[i].r1});
            ex.push_back(vt[i].e0);
            ex.push_back(vt[i].e1);
            expect_bytes(0, $sformatf("tab%0d", i));
            check($sformatf("tab%0d_outst", i), outst[0], 1);
            check($sformatf("tab%0d_fsent", i), fsent[0], i + 1);
            repeat (4) @(negedge clk);
            check($sformatf("tab%0d_hdr_held", i), ov[0], 0);
            check($sformatf("tab%0d_no_bytes", i), cap[0].size(), 0);
            pulse_done(0);
            @(negedge clk);
            check($sformatf("tab%0d_outst_ret", i), outst[0], 0);
        end

        // Random rounds with random output_ready against the byte model.
        fs_model   = 4;
        rand_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            r0 = 12'($urandom_range(0, 15));
            r1 = 12'($urandom_range(0, 15));
            ex.push_back(8'h02);
            give_round(0, r0);
            model_round(1, r0);
            give_round(0, r1);
            model_round(1, r1);
            expect_bytes(0, $sformatf("rnd%0d", k));
            fs_model++;
            check($sformatf("rnd%0d_fsent", k), fsent[0], fs_model);
            check($sformatf("rnd%0d_outst", k), outst[0], 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse_done(0);
            @(negedge clk);
            check($sformatf("rnd%0d_outst_ret", k), outst[0], 0);
        end
        rand_ready = 1'b0;
        @(posedge clk); #1;
        ordy[0] = 1'b1;

        // Result with nothing in flight: sticky error, counter floor at zero.
        pulse_done(0);
        @(negedge clk);
        check("perr_set", perr[0], 1);
        check("perr_outst", outst[0], 0);
        repeat (3) @(negedge clk);
        check("perr_sticky", perr[0], 1);

        // Reset two bytes into a frame.
        ex.push_back(8'h02);
        give_round(0, 12'h006);
        ex.push_back(8'h06);
        expect_bytes(0, "pre_reset");
        @(posedge clk); #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        cap[0].delete();
        @(negedge clk);
        check("mrst_fsent", fsent[0], 0);
        check("mrst_outst", outst[0], 0);
        check("mrst_perr", perr[0], 0);
        ex.push_back(8'h01);
        ex.push_back(8'h02);
        expect_bytes(0, "post_reset");

        // 6x2 grid, one round: two bytes, stalled on the second byte.
        @(posedge clk); #1;
        ordy[1] = 1'b1;
        ex.push_back(8'h01);
        expect_bytes(1, "start_b");
        give_round(1, 12'hABC);
        @(negedge clk);
        check("b_byte0_data", od[1], 8'hBC);
        check("b_byte0_rready", rr[1], 0);
        @(posedge clk); #1;
        ordy[1] = 1'b0;
        @(negedge clk);
        check("b_stall1_data", od[1], 8'h0A);
        check("b_stall1_rready", rr[1], 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("b_stall2_data", od[1], 8'h0A);
        check("b_stall2_rready", rr[1], 0);
        @(posedge clk); #1;
        ordy[1] = 1'b1;
        ex.push_back(8'h02);
        model_round(2, 12'hABC);
        expect_bytes(1, "b_frame");
        check("b_fsent", fsent[1], 1);
        check("b_outst", outst[1], 1);

        // Two credits: back-to-back frames, coincident result, held header.
        @(posedge clk); #1;
        ordy[2] = 1'b1;
        ex.push_back(8'h01);
        ex.push_back(8'h02);
        give_round(2, 12'h001);
        model_round(1, 12'h001);
        give_round(2, 12'h002);
        model_round(1, 12'h002);
        expect_bytes(2, "c_f1");
        check("c_f1_outst", outst[2], 1);
        check("c_f1_fsent", fsent[2], 1);
        ex.push_back(8'h02);
        give_round(2, 12'h003);
        model_round(1, 12'h003);
        give_round(2, 12'h004);
        model_round(1, 12'h004);
        rdone[2] = 1'b1;
        @(posedge clk); #1;
        rdone[2] = 1'b0;
        @(negedge clk);
        check("c_coinc_outst", outst[2], 1);
        check("c_coinc_fsent", fsent[2], 2);
        expect_bytes(2, "c_f2");
        ex.push_back(8'h02);
        give_round(2, 12'h005);
        model_round(1, 12'h005);
        give_round(2, 12'h006);
        model_round(1, 12'h006);
        expect_bytes(2, "c_f3");
        check("c_f3_outst", outst[2], 2);
        check("c_f3_fsent", fsent[2], 3);
        repeat (4) @(negedge clk);
        check("c_hdr_held", ov[2], 0);
        check("c_no_bytes", cap[2].size(), 0);
        pulse_done(2);
        @(negedge clk);
        check("c_outst_ret", outst[2], 1);
        ex.push_back(8'h02);
        expect_bytes(2, "c_hdr_release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
